// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and transmit state encodings
// UART_TX_PARITY_EN widens the state type to add the PARITY state.
package uart_pkg;

  localparam int   DEFAULT_CLKS_PER_BIT = 8;
  localparam int   DATA_BITS            = 8;
  localparam logic LINE_IDLE            = 1'b1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b010,
    STOP   = 3'b011,
    PARITY = 3'b100
  } tx_state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } tx_state_t;
`endif

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// rtl/uart_baud_counter.sv - bit-period counter with one-cycle bit_end tick
// Shared with the receive side; restart holds the count at zero.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic Clock,
  input  logic Reset,
  input  logic restart,
  output logic bit_end
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge Clock) begin
    if (Reset || restart) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign bit_end = !restart && (count == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8N1 UART transmit engine, registered line output
// Defining UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = uart_pkg::DATA_BITS
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 TxStart,
  input  logic [DATA_BITS-1:0] TxDataIn,
  output logic                 TxDataOut,
  output logic                 TxBusy,
  output logic                 TxDone
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t            state, state_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic [2:0]           bit_q, bit_n, bit_next;
  logic                 tx_q, tx_n;
  logic                 busy_q, busy_n;
  logic                 done_q, done_n;
  logic                 restart;
  logic                 bit_end;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .Clock   (Clock),
    .Reset   (Reset),
    .restart (restart),
    .bit_end (bit_end)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= LINE_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      shift_q <= shift_n;
      bit_q   <= bit_n;
      tx_q    <= tx_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  assign bit_next = bit_q + 3'd1;

  // Outputs are computed one cycle ahead so the line changes exactly on bit boundaries.
  always_comb begin
    state_n = state;
    shift_n = shift_q;
    bit_n   = bit_q;
    tx_n    = tx_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    restart = 1'b0;
    case (state)
      IDLE: begin
        restart = 1'b1;
        tx_n    = LINE_IDLE;
        busy_n  = 1'b0;
        if (TxStart) begin
          state_n = START;
          shift_n = TxDataIn;
          bit_n   = '0;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          bit_n   = '0;
          tx_n    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = even_parity(shift_q);
`else
            state_n = STOP;
            tx_n    = LINE_IDLE;
`endif
          end else begin
            bit_n = bit_next;
            tx_n  = shift_q[bit_next];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          tx_n    = LINE_IDLE;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_n = IDLE;
          tx_n    = LINE_IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = LINE_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign TxDataOut = tx_q;
  assign TxBusy    = busy_q;
  assign TxDone    = done_q;

endmodule
